// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: one-hot SEL routes DI into one of four one-entry valid/ack slots.
// Define DEMUX_ERRCNT_EN to build the saturating illegal-select counter; otherwise ERR_CNT reads zero.
module demux_1to4_buf #(
   parameter int BITWIDTH = 32
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic [BITWIDTH-1:0] DI,
   input  logic [3:0]          SEL,
   input  logic                VALID_IN,
   output logic                READY_OUT,
   output logic [BITWIDTH-1:0] DO0,
   output logic [BITWIDTH-1:0] DO1,
   output logic [BITWIDTH-1:0] DO2,
   output logic [BITWIDTH-1:0] DO3,
   output logic [3:0]          VLD,
   input  logic [3:0]          ACK,
   output logic [7:0]          ERR_CNT
);

   logic [BITWIDTH-1:0] do_q [4];
   logic [BITWIDTH-1:0] do_d [4];
   logic [3:0]          vld_q;
   logic [3:0]          vld_d;
   logic [3:0]          slot_free;
   logic [3:0]          wr_en;
   logic                sel_legal;

   // Unknown bits never count as a legal select, so an X/Z SEL cannot write a slot.
   function automatic logic onehot_legal(input logic [3:0] s);
      return !$isunknown(s) && $onehot(s);
   endfunction

   always_comb begin
      sel_legal = onehot_legal(SEL);
      slot_free = ~vld_q | ACK;
      READY_OUT = VALID_IN & sel_legal & (|(SEL & slot_free));
      wr_en     = SEL & {4{READY_OUT}};
      // A write wins over a drain on the same slot, giving bubble-free refill.
      vld_d     = (vld_q & ~ACK) | wr_en;
      for (int k = 0; k < 4; k++) begin
         do_d[k] = wr_en[k] ? DI : do_q[k];
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         vld_q <= '0;
         for (int k = 0; k < 4; k++) begin
            do_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < 4; k++) begin
            do_q[k] <= do_d[k];
         end
      end
   end

   assign DO0 = do_q[0];
   assign DO1 = do_q[1];
   assign DO2 = do_q[2];
   assign DO3 = do_q[3];
   assign VLD = vld_q;

`ifdef DEMUX_ERRCNT_EN
   logic [7:0] err_cnt_q;
   logic [7:0] err_cnt_d;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Back-pressure on a legal select is not an error; only illegal selects count.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (VALID_IN && !sel_legal) begin
         err_cnt_d = sat_inc8(err_cnt_q);
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign ERR_CNT = err_cnt_q;
`else
   assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Scoreboard bench for demux_1to4_buf: per-port word queues model the holding slots.
module tb_demux_1to4_buf;
   localparam int BW = 32;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic [BW-1:0] DI = '0;
   logic [3:0]    SEL = '0;
   logic          VALID_IN = 1'b0;
   logic          READY_OUT;
   logic [BW-1:0] DO0, DO1, DO2, DO3;
   logic [3:0]    VLD;
   logic [3:0]    ACK = '0;
   logic [7:0]    ERR_CNT;

   always #5 CLK = ~CLK;

   demux_1to4_buf #(.BITWIDTH(BW)) dut (
      .CLK(CLK), .RSTN(RSTN), .DI(DI), .SEL(SEL), .VALID_IN(VALID_IN),
      .READY_OUT(READY_OUT), .DO0(DO0), .DO1(DO1), .DO2(DO2), .DO3(DO3),
      .VLD(VLD), .ACK(ACK), .ERR_CNT(ERR_CNT)
   );

   typedef struct packed {
      logic       rdy;
      logic [3:0] vld;
      logic [3:0] ack;
      logic [7:0] err;
   } chk_t;

   chk_t          chk_q [$];
   logic [BW-1:0] sb [4][$];
   logic [BW-1:0] last_do [4];
   logic [3:0]    occ;
   int            err_m;
   int            n_tests = 0;
   int            n_fail = 0;

   function automatic logic [BW-1:0] dout(input int k);
      case (k)
         0: return DO0;
         1: return DO1;
         2: return DO2;
         default: return DO3;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the reference model decides the slot outcome from occupancy and ACK.
   task automatic step(input logic rstn_v, input logic v, input logic [3:0] s,
                       input logic [BW-1:0] d, input logic [3:0] a);
      chk_t c;
      logic sel_ok;
      logic rdy;
      int   k;
      @(posedge CLK);
      #1;
      RSTN = rstn_v; VALID_IN = v; SEL = s; DI = d; ACK = a;
      if (!rstn_v) begin
         occ = '0;
         err_m = 0;
         for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            last_do[i] = '0;
         end
         c.rdy = 1'b0; c.vld = '0; c.ack = '0; c.err = '0;
         chk_q.push_back(c);
      end else begin
         sel_ok = !$isunknown(s) && ($countones(s) == 1);
         k = 0;
         for (int i = 0; i < 4; i++) if (sel_ok && s[i]) k = i;
         rdy = v && sel_ok && (!occ[k] || a[k]);
         c.rdy = rdy; c.vld = occ; c.ack = a;
`ifdef DEMUX_ERRCNT_EN
         c.err = 8'(err_m);
`else
         c.err = 8'd0;
`endif
         chk_q.push_back(c);
         occ = occ & ~a;
         if (rdy) begin
            occ[k] = 1'b1;
            sb[k].push_back(d);
         end
         if (v && !sel_ok && err_m < 255) err_m++;
      end
   endtask

   // Monitor: compares handshake/status every cycle and pops a slot's word when it is consumed.
   initial begin
      chk_t c;
      forever begin
         @(negedge CLK);
         if (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            check("ready_out", 64'(READY_OUT), 64'(c.rdy));
            check("vld", 64'(VLD), 64'(c.vld));
            check("err_cnt", 64'(ERR_CNT), 64'(c.err));
            for (int k = 0; k < 4; k++) begin
               if (c.vld[k]) begin
                  if (sb[k].size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL sb_underflow%0d: got empty queue required a word", k);
                  end else begin
                     check($sformatf("do%0d", k), 64'(dout(k)), 64'(sb[k][0]));
                     if (c.ack[k]) last_do[k] = sb[k].pop_front();
                  end
               end else begin
                  check($sformatf("do%0d_hold", k), 64'(dout(k)), 64'(last_do[k]));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] s;
      logic [3:0] xsel;
      occ = '0;
      err_m = 0;
      for (int i = 0; i < 4; i++) last_do[i] = '0;
      xsel = 4'bx00x;

      step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);

      // Basic routing, then partial drain to 1011 and reset mid-stream.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 4'(1 << k), BW'(k), 4'b0000);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0100);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);

      // Refill all, independent drain of ports 0 and 2.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 4'(1 << k), BW'(32'h100 + k), 4'b0000);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0101);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);

      // Back-pressure on port 2, then release with a same-cycle ACK.
      step(1'b1, 1'b1, 4'b0100, 32'h77, 4'b0000);
      step(1'b1, 1'b1, 4'b0100, 32'hA5, 4'b0000);
      step(1'b1, 1'b1, 4'b0100, 32'hA5, 4'b0000);
      step(1'b1, 1'b1, 4'b0100, 32'hA5, 4'b0100);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);

      // Streaming into port 0 with continuous ACK.
      for (int i = 10; i < 14; i++) step(1'b1, 1'b1, 4'b0001, BW'(i), 4'b0001);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b1111);

      // Illegal selects, then saturation of the error counter.
      step(1'b1, 1'b1, 4'b0000, 32'hDEAD, 4'b0000);
      step(1'b1, 1'b1, 4'b0011, 32'hDEAD, 4'b0000);
      step(1'b1, 1'b1, xsel, 32'hDEAD, 4'b0000);
      for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 4'b0110, BW'(i), 4'b0000);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, '0, 4'b0000);

      // Randomized traffic with occasional illegal selects and random ACKs.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) < 6) s = 4'(1 << $urandom_range(0, 3));
         else s = 4'($urandom_range(0, 15));
         step(1'b1, ($urandom_range(0, 3) != 0), s, $urandom, 4'($urandom_range(0, 15)));
      end

      step(1'b1, 1'b0, 4'b0000, '0, 4'b1111);
      step(1'b1, 1'b0, 4'b0000, '0, 4'b0000);
      @(negedge CLK);
      #1;
      for (int k = 0; k < 4; k++) check($sformatf("sb_empty%0d", k), 64'(sb[k].size()), 64'd0);
      check("chk_q_empty", 64'(chk_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
